// File: rtl/pcie_tlp_tx_framer.sv
// PCIe TLP transmit framer: accepts one decoded descriptor, emits a 3DW
// header plus optional payload as a 32-bit DW stream, and allocates
// request tags.
module pcie_tlp_tx_framer #(
  parameter int          MAX_PAYLOAD_DW = 32,
  parameter logic [15:0] REQ_ID         = 16'h0100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tlp_valid_i,
  output logic                        tlp_ready_o,
  input  logic [2:0]                  fmt_i,
  input  logic [4:0]                  type_i,
  input  logic [2:0]                  tc_i,
  input  logic [9:0]                  length_i,
  input  logic [15:0]                 requester_id_i,
  input  logic [15:0]                 completer_id_i,
  input  logic [7:0]                  cpl_tag_i,
  input  logic [31:0]                 addr_i,
  input  logic [32*MAX_PAYLOAD_DW-1:0] data_i,
  output logic [31:0]                 tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic                        tx_sop_o,
  output logic                        tx_eop_o,
  output logic                        err_unsup_o
);

  localparam int         IDX_W   = (MAX_PAYLOAD_DW > 1) ? $clog2(MAX_PAYLOAD_DW) : 1;
  localparam logic [9:0] MAX_LEN = 10'(MAX_PAYLOAD_DW);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                        state_q;
  logic [1:0]                    hdr_idx_q;
  logic [IDX_W-1:0]              dat_idx_q;
  logic [7:0]                    tag_q;
  logic [15:0]                   req_id_q;
  logic [31:0]                   tx_data_q;
  logic                          tx_valid_q, tx_sop_q, tx_eop_q, err_q;

  // Descriptor fields captured at accept (datapath, not reset).
  logic                          is_cpl_q, has_data_q;
  logic [9:0]                    len_q;
  logic [15:0]                   cid_q;
  logic [7:0]                    ctag_q, rtag_q;
  logic [31:0]                   addr_q;
  logic [32*MAX_PAYLOAD_DW-1:0]  data_q;

  logic                          is_req_d, is_cpl_d, supported_d, accept_d;
  logic [IDX_W-1:0]              dat_nxt_d;
  logic [9:0]                    dat_idx_ext_d, nxt_idx_ext_d;
  logic [31:0]                   dw0_d, dw1_d, dw2_d;

  assign tlp_ready_o = (state_q == IDLE);
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_sop_o    = tx_sop_q;
  assign tx_eop_o    = tx_eop_q;
  assign err_unsup_o = err_q;

  // Classify the incoming descriptor and build its first header DW.
  always_comb begin
    is_req_d    = 1'b0;
    is_cpl_d    = 1'b0;
    if (type_i == 5'b00000) begin
      if (fmt_i == 3'b000) is_req_d = (length_i != 10'd0);
      if (fmt_i == 3'b010) is_req_d = (length_i != 10'd0) && (length_i <= MAX_LEN);
    end else if (type_i == 5'b01010) begin
      if (fmt_i == 3'b000) is_cpl_d = 1'b1;
      if (fmt_i == 3'b010) is_cpl_d = (length_i != 10'd0) && (length_i <= MAX_LEN);
    end
    supported_d = is_req_d || is_cpl_d;
    accept_d    = tlp_valid_i && (state_q == IDLE) && supported_d;
    dw0_d       = {fmt_i, type_i, 1'b0, tc_i, 4'b0000, 2'b00, 2'b00, 2'b00, length_i};
  end

  // Header DW1/DW2 from captured fields; payload index bookkeeping.
  always_comb begin
    if (is_cpl_q) begin
      dw1_d = {cid_q, 3'b000, 1'b0, len_q, 2'b00};
      dw2_d = {req_id_q, ctag_q, 1'b0, addr_q[6:0]};
    end else begin
      dw1_d = {req_id_q, rtag_q, ((len_q > 10'd1) ? 4'hF : 4'h0), 4'hF};
      dw2_d = {addr_q[31:2], 2'b00};
    end
    dat_nxt_d     = dat_idx_q + 1'b1;
    dat_idx_ext_d = 10'(dat_idx_q);
    nxt_idx_ext_d = 10'(dat_nxt_d);
  end

  // Capture descriptor payload and fields so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept_d) begin
      is_cpl_q   <= is_cpl_d;
      has_data_q <= fmt_i[1];
      len_q      <= length_i;
      cid_q      <= completer_id_i;
      ctag_q     <= cpl_tag_i;
      rtag_q     <= tag_q;
      addr_q     <= addr_i;
      data_q     <= data_i;
    end
  end

  // Framing FSM with registered stream outputs, tag counter and error pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      hdr_idx_q  <= 2'd0;
      dat_idx_q  <= '0;
      tag_q      <= 8'd0;
      req_id_q   <= REQ_ID;
      tx_data_q  <= 32'd0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tlp_valid_i) begin
            if (supported_d) begin
              state_q    <= HDR;
              hdr_idx_q  <= 2'd0;
              req_id_q   <= requester_id_i;
              tx_data_q  <= dw0_d;
              tx_valid_q <= 1'b1;
              tx_sop_q   <= 1'b1;
              tx_eop_q   <= 1'b0;
              if (is_req_d) tag_q <= tag_q + 8'd1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        HDR: begin
          if (tx_ready_i) begin
            case (hdr_idx_q)
              2'd0: begin
                hdr_idx_q <= 2'd1;
                tx_data_q <= dw1_d;
                tx_sop_q  <= 1'b0;
              end
              2'd1: begin
                hdr_idx_q <= 2'd2;
                tx_data_q <= dw2_d;
                tx_eop_q  <= !has_data_q;
              end
              default: begin
                if (has_data_q) begin
                  state_q   <= DATA;
                  dat_idx_q <= '0;
                  tx_data_q <= data_q[31:0];
                  tx_eop_q  <= (len_q == 10'd1);
                end else begin
                  state_q    <= IDLE;
                  tx_valid_q <= 1'b0;
                  tx_eop_q   <= 1'b0;
                end
              end
            endcase
          end
        end
        DATA: begin
          if (tx_ready_i) begin
            if (dat_idx_ext_d == len_q - 10'd1) begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              tx_eop_q   <= 1'b0;
            end else begin
              dat_idx_q <= dat_nxt_d;
              tx_data_q <= data_q[32*dat_nxt_d +: 32];
              tx_eop_q  <= (nxt_idx_ext_d == len_q - 10'd1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tlp_tx_framer.sv
// Directed bench for pcie_tlp_tx_framer with hand-computed DW streams.
module tb_pcie_tlp_tx_framer;

  localparam int MAX = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tlp_valid_i;
  logic             tlp_ready_o;
  logic [2:0]       fmt_i;
  logic [4:0]       type_i;
  logic [2:0]       tc_i;
  logic [9:0]       length_i;
  logic [15:0]      requester_id_i, completer_id_i;
  logic [7:0]       cpl_tag_i;
  logic [31:0]      addr_i;
  logic [32*MAX-1:0] data_i;
  logic [31:0]      tx_data_o;
  logic             tx_valid_o, tx_ready_i, tx_sop_o, tx_eop_o, err_unsup_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [0:15];
  int k;

  pcie_tlp_tx_framer #(.MAX_PAYLOAD_DW(MAX), .REQ_ID(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .tlp_valid_i(tlp_valid_i), .tlp_ready_o(tlp_ready_o),
    .fmt_i(fmt_i), .type_i(type_i), .tc_i(tc_i), .length_i(length_i),
    .requester_id_i(requester_id_i), .completer_id_i(completer_id_i),
    .cpl_tag_i(cpl_tag_i), .addr_i(addr_i), .data_i(data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .err_unsup_o(err_unsup_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a descriptor for one edge; returns one cycle after the handshake edge.
  task automatic send(input logic [2:0] f, input logic [4:0] t, input logic [9:0] len,
                      input logic [15:0] rid, input logic [15:0] cid,
                      input logic [7:0] ctag, input logic [31:0] a);
    fmt_i = f; type_i = t; tc_i = 3'd0; length_i = len;
    requester_id_i = rid; completer_id_i = cid; cpl_tag_i = ctag; addr_i = a;
    tlp_valid_i = 1'b1;
    step();
    tlp_valid_i = 1'b0;
  endtask

  // Expect n DWs from exp_q back-to-back with tx_ready_i held high.
  task automatic rx(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_vld%0d", nm, i), tx_valid_o, 1'b1);
      chk($sformatf("%s_dw%0d", nm, i), tx_data_o, exp_q[i]);
      chk($sformatf("%s_sop%0d", nm, i), tx_sop_o, (i == 0));
      chk($sformatf("%s_eop%0d", nm, i), tx_eop_o, (i == n - 1));
      chk($sformatf("%s_rdy%0d", nm, i), tlp_ready_o, 1'b0);
      step();
    end
    chk($sformatf("%s_idle_vld", nm), tx_valid_o, 1'b0);
    chk($sformatf("%s_idle_rdy", nm), tlp_ready_o, 1'b1);
  endtask

  task automatic bad(input string nm, input logic [2:0] f, input logic [4:0] t, input logic [9:0] len);
    chk({nm, "_err_pre"}, err_unsup_o, 1'b0);
    send(f, t, len, 16'h0100, 16'h0, 8'h0, 32'h0);
    chk({nm, "_err"}, err_unsup_o, 1'b1);
    chk({nm, "_vld"}, tx_valid_o, 1'b0);
    chk({nm, "_rdy"}, tlp_ready_o, 1'b1);
    step();
    chk({nm, "_err_post"}, err_unsup_o, 1'b0);
    chk({nm, "_vld_post"}, tx_valid_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; tlp_valid_i = 1'b0; tx_ready_i = 1'b1;
    fmt_i = '0; type_i = '0; tc_i = '0; length_i = '0;
    requester_id_i = '0; completer_id_i = '0; cpl_tag_i = '0; addr_i = '0; data_i = '0;
    step();
    chk("rst_vld", tx_valid_o, 1'b0);
    chk("rst_sop", tx_sop_o, 1'b0);
    chk("rst_eop", tx_eop_o, 1'b0);
    chk("rst_err", err_unsup_o, 1'b0);
    chk("rst_data", tx_data_o, 32'h0);
    chk("rst_rdy", tlp_ready_o, 1'b1);
    rst_n = 1'b0;
    step();

    // MWr len 8, tag 0
    for (int i = 0; i < 8; i++) data_i[32*i +: 32] = 32'h01234567;
    send(3'b010, 5'b00000, 10'd8, 16'h0100, 16'h0, 8'h0, 32'h0);
    exp_q[0] = 32'h40000008; exp_q[1] = 32'h010000FF; exp_q[2] = 32'h00000000;
    for (int i = 3; i < 11; i++) exp_q[i] = 32'h01234567;
    rx("mwr8", 11);

    // MRd len 4, tag 1
    send(3'b000, 5'b00000, 10'd4, 16'h0100, 16'h0, 8'h0, 32'h20);
    exp_q[0] = 32'h00000004; exp_q[1] = 32'h010001FF; exp_q[2] = 32'h00000020;
    rx("mrd4", 3);

    // CplD len 2; inputs scrambled after accept must not leak into the stream
    data_i = '0;
    data_i[31:0] = 32'hAAAA5555; data_i[63:32] = 32'h12345678;
    send(3'b010, 5'b01010, 10'd2, 16'h0100, 16'h0200, 8'h05, 32'h20);
    data_i = {MAX{32'hDEAD0000}}; addr_i = 32'hFFFFFFFF; requester_id_i = 16'hBEEF;
    exp_q[0] = 32'h4A000002; exp_q[1] = 32'h02000008; exp_q[2] = 32'h01000520;
    exp_q[3] = 32'hAAAA5555; exp_q[4] = 32'h12345678;
    rx("cpld2", 5);

    // MWr len 1 with tx_ready_i pattern 1-0-0-1; tag 2 (completion left it alone)
    data_i = '0; data_i[31:0] = 32'hDEADBEEF;
    send(3'b010, 5'b00000, 10'd1, 16'h0100, 16'h0, 8'h0, 32'h40);
    exp_q[0] = 32'h40000001; exp_q[1] = 32'h0100020F; exp_q[2] = 32'h00000040;
    exp_q[3] = 32'hDEADBEEF;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      tx_ready_i = ((c % 4) == 0) || ((c % 4) == 3);
      if (tx_valid_o && k < 4) begin
        chk($sformatf("stall_dw%0d_c%0d", k, c), tx_data_o, exp_q[k]);
        chk($sformatf("stall_sop%0d_c%0d", k, c), tx_sop_o, (k == 0));
        chk($sformatf("stall_eop%0d_c%0d", k, c), tx_eop_o, (k == 3));
        if (tx_ready_i) k++;
      end
      step();
    end
    tx_ready_i = 1'b1;
    chk("stall_count", k, 4);
    chk("stall_idle_vld", tx_valid_o, 1'b0);

    // Unsupported / out-of-range descriptors
    bad("fmt011", 3'b011, 5'b00000, 10'd1);
    bad("mwr_len0", 3'b010, 5'b00000, 10'd0);
    bad("mwr_len33", 3'b010, 5'b00000, 10'd33);

    // MRd len 1 proves tag stayed at 3 through the drops
    send(3'b000, 5'b00000, 10'd1, 16'h0100, 16'h0, 8'h0, 32'h4);
    exp_q[0] = 32'h00000001; exp_q[1] = 32'h0100030F; exp_q[2] = 32'h00000004;
    rx("mrd1", 3);

    // Reset during payload DW 3 of a len-8 MWr
    for (int i = 0; i < 8; i++) data_i[32*i +: 32] = 32'h10000000 + i;
    send(3'b010, 5'b00000, 10'd8, 16'h0100, 16'h0, 8'h0, 32'h80);
    for (int i = 0; i < 6; i++) step();
    chk("rstmid_dw", tx_data_o, 32'h10000003);
    chk("rstmid_vld_pre", tx_valid_o, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rstmid_vld", tx_valid_o, 1'b0);
    chk("rstmid_eop", tx_eop_o, 1'b0);
    chk("rstmid_rdy", tlp_ready_o, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    step();
    send(3'b000, 5'b00000, 10'd4, 16'h0100, 16'h0, 8'h0, 32'h20);
    exp_q[0] = 32'h00000004; exp_q[1] = 32'h010000FF; exp_q[2] = 32'h00000020;
    rx("post_rst", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_tlp_tx_framer.md
Name: pcie_tlp_tx_framer

Overview:
- Sits directly downstream of the PCIe AXI-to-TLP bridge.
- Consumes one decoded TLP descriptor per handshake: header fields, 32-bit address and up to 32 DW of payload.
- Serializes the descriptor into a 32-bit DW stream (3DW header, then payload) toward the link/transmit buffer.
- Owns tag allocation for non-posted and posted requests.

Parameters:
- MAX_PAYLOAD_DW, 32, maximum payload DWs accepted; payload bus width is 32*MAX_PAYLOAD_DW.
- REQ_ID, 16'h0100, reset value of the requester ID register (unused; requester ID comes from port, kept for bring-up default).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- tlp_valid_i  in  1  descriptor valid
- tlp_ready_o  out  1  descriptor accepted when valid&ready
- fmt_i  in  3  TLP fmt
- type_i  in  5  TLP type
- tc_i  in  3  traffic class
- length_i  in  10  length in DW
- requester_id_i  in  16  requester ID
- completer_id_i  in  16  completer ID (completions only)
- cpl_tag_i  in  8  tag of the request being completed (completions only)
- addr_i  in  32  byte address
- data_i  in  32*MAX_PAYLOAD_DW  payload; DW i = data_i[32*i +: 32]
- tx_data_o  out  32  stream DW
- tx_valid_o  out  1  stream valid
- tx_ready_i  in  1  stream ready
- tx_sop_o  out  1  first DW of TLP
- tx_eop_o  out  1  last DW of TLP
- err_unsup_o  out  1  one-cycle pulse: descriptor dropped

Behaviour:
- Reset (rst_n=1, async):
  - State=IDLE; tx_valid_o, tx_sop_o, tx_eop_o, err_unsup_o=0; tx_data_o=0.
  - Tag counter=0.
  - tlp_ready_o=1 (it is tlp_ready_o = state==IDLE).
  - Reset mid-TLP abandons the partial TLP immediately; no eop is emitted.
- Supported descriptors:
  - MRd: fmt 000, type 00000, length 1..1023.
  - MWr: fmt 010, type 00000, length 1..MAX_PAYLOAD_DW.
  - Cpl: fmt 000, type 01010.
  - CplD: fmt 010, type 01010, length 1..MAX_PAYLOAD_DW.
- Any other fmt/type, or length out of range, on a handshake:
  - Descriptor dropped.
  - err_unsup_o pulses the following cycle.
  - State stays IDLE; tag unchanged.
- FSM states: IDLE -> HDR -> (DATA if fmt[1]) -> IDLE.
  - IDLE: on valid&ready, capture all inputs into registers; enter HDR with hdr_idx=0 next cycle.
  - HDR: drive header DW hdr_idx. On tx handshake, hdr_idx++. After DW2, go to DATA (dat_idx=0) if fmt[1], else IDLE.
  - DATA: drive payload DW dat_idx. On tx handshake, dat_idx++. After DW length-1, go to IDLE.
- Stream handshake:
  - tx_valid_o=1 in HDR/DATA.
  - tx_data_o, tx_sop_o and tx_eop_o are stable while tx_valid_o&!tx_ready_i.
  - A DW advances only on tx_valid_o&tx_ready_i.
  - tx_sop_o=1 on header DW0.
  - tx_eop_o=1 on header DW2 (no data) or on last payload DW.
- Throughput: one idle cycle between TLPs, since a descriptor is accepted only in IDLE. Latency from accept to DW0 valid is 1 cycle.
- Header DW0: {fmt, type, 1'b0, tc, 4'b0, 2'b00 (TD/EP), 2'b00 (attr), 2'b00, length}.
- Requests (MRd/MWr):
  - DW1 = {requester_id, tag, last_be, first_be}.
  - first_be=4'hF. last_be=4'hF if length>1, else 4'h0.
  - DW2 = {addr[31:2], 2'b00}.
  - tag = tag counter value at accept; the counter increments by 1 (8-bit, wraps 255->0) on each accepted request.
- Completions (Cpl/CplD):
  - DW1 = {completer_id, 3'b000 status, 1'b0 BCM, byte_count[11:0]}, with byte_count = length*4 truncated to 12 bits.
  - DW2 = {requester_id, cpl_tag_i, 1'b0, addr[6:0]}.
  - Tag counter is not affected.
- Register capture: data_i changes after accept do not affect the TLP in flight.

Test Plan:
- MWr after reset: fmt 010, type 0, tc 0, len 8, req_id 0x0100, addr 0x0, data {8{32'h01234567}}; tx_ready_i=1.
  - Expect DWs 0x40000008, 0x010000FF, 0x00000000, then 8x 0x01234567.
  - sop on DW 1, eop on DW 11; tlp_ready_o low for 11 cycles, high the cycle after eop.
- MRd next: len 4, addr 0x20.
  - Expect 0x00000004, 0x010001FF (tag 1), 0x00000020; eop on DW2; no payload.
- CplD: len 2, completer 0x0200, requester 0x0100, cpl_tag 0x05, addr 0x20, data DW0=0xAAAA5555, DW1=0x12345678.
  - Expect 0x4A000002, 0x02000008, 0x01000520, 0xAAAA5555, 0x12345678.
  - Tag counter unchanged.
- MWr len 1 with tx_ready_i toggling 1-0-0-1 per cycle.
  - Expect DW1 last_be=0: 0x0100xx0F.
  - Every DW held stable through stall cycles; exactly 4 DWs transferred.
- Unsupported fmt 011 type 00000, and MWr len 0 / len 33.
  - Expect each dropped with a 1-cycle err_unsup_o; tx_valid_o never rises; tag unchanged.
- Assert rst_n during payload DW 3 of a len-8 MWr.
  - Expect tx_valid_o=0 asynchronously and tag=0.
  - Next MRd after release carries tag 0x00 and a fresh sop.
